// File: rtl/way_select_pipe.sv
// Registered N-way line/word selector between tag compare and load return.
// Two-entry skid buffer (main drives outputs, skid holds one more) keeps full throughput with a registered o_ready.
module way_select_pipe #(
   parameter  int LINE_SIZE_BYTES = 32,
   parameter  int WAYS            = 4,
   parameter  int WORD_BYTES      = 4,
   parameter  int ERR_CNT_W       = 8,
   localparam int LB              = LINE_SIZE_BYTES * 8,
   localparam int WI              = $clog2(WAYS),
   localparam int WB              = WORD_BYTES * 8,
   localparam int NW              = LINE_SIZE_BYTES / WORD_BYTES,
   localparam int OW              = $clog2(NW)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [LB-1:0]        i_data [WAYS-1:0],
   input  logic [WAYS-1:0]      i_sel,
   input  logic [OW-1:0]        i_offset,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [LB-1:0]        o_line,
   output logic [WB-1:0]        o_word,
   output logic [WI-1:0]        o_way,
   output logic                 o_hit,
   output logic                 o_multi_hit,
   input  logic                 i_err_clr,
   output logic [ERR_CNT_W-1:0] o_err_cnt,
   output logic [1:0]           o_dbg_state
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   typedef struct packed {
      logic [LB-1:0] line;
      logic [WB-1:0] word;
      logic [WI-1:0] way;
      logic          hit;
      logic          multi;
   } entry_t;

   state_t               state_q, state_d;
   entry_t               main_q, main_d;
   entry_t               skid_q, skid_d;
   entry_t               sel_ent;
   logic                 ready_q, ready_d;
   logic [ERR_CNT_W-1:0] err_q, err_d;
   logic                 push, pop;

   // Walk from the top down so the lowest-index hitting way is the last writer.
   always_comb begin
      sel_ent = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (i_sel[w]) begin
            sel_ent.line = i_data[w];
            sel_ent.way  = WI'(w);
         end
      end
      sel_ent.hit   = |i_sel;
      sel_ent.multi = |(i_sel & (i_sel - WAYS'(1)));
      for (int k = 0; k < NW; k++) begin
         if (i_offset == OW'(k)) sel_ent.word = sel_ent.line[k*WB +: WB];
      end
   end

   assign push = i_valid & ready_q;
   assign pop  = (state_q != EMPTY) & i_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (push) begin
               main_d  = sel_ent;
               state_d = ONE;
            end
         end
         ONE: begin
            if (push && pop) begin
               main_d = sel_ent;
            end else if (push) begin
               skid_d  = sel_ent;
               state_d = FULL;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               main_d  = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      ready_d = (state_d != FULL);
   end

   // Clear wins over a same-cycle multi-hit increment.
   always_comb begin
      err_d = err_q;
      if (i_err_clr) begin
         err_d = '0;
      end else if (push && sel_ent.multi && (err_q != {ERR_CNT_W{1'b1}})) begin
         err_d = err_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b1;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   assign o_valid     = (state_q != EMPTY);
   assign o_ready     = ready_q;
   assign o_line      = main_q.line;
   assign o_word      = main_q.word;
   assign o_way       = main_q.way;
   assign o_hit       = main_q.hit;
   assign o_multi_hit = main_q.multi;
   assign o_err_cnt   = err_q;
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_way_select_pipe.sv
// Bench for way_select_pipe: driver tasks push expected results into exp_q,
// a negedge monitor pops and compares whenever a result is handed downstream.
module tb_way_select_pipe;

   localparam int EW = 256 + 32 + 2 + 1 + 1;

   logic         clk;
   logic         rst_n;
   logic         i_valid;
   logic         o_ready;
   logic [255:0] data [3:0];
   logic [3:0]   i_sel;
   logic [2:0]   i_offset;
   logic         o_valid;
   logic         i_ready;
   logic [255:0] o_line;
   logic [31:0]  o_word;
   logic [1:0]   o_way;
   logic         o_hit;
   logic         o_multi_hit;
   logic         i_err_clr;
   logic [7:0]   o_err_cnt;
   logic [1:0]   o_dbg_state;

   logic [EW-1:0] exp_q[$];
   int checks   = 0;
   int failures = 0;
   int stalls   = 0;

   way_select_pipe dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_data      (data),
      .i_sel       (i_sel),
      .i_offset    (i_offset),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_line      (o_line),
      .o_word      (o_word),
      .o_way       (o_way),
      .o_hit       (o_hit),
      .o_multi_hit (o_multi_hit),
      .i_err_clr   (i_err_clr),
      .o_err_cnt   (o_err_cnt),
      .o_dbg_state (o_dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // reference: first set bit from way 0 upward wins
   function automatic logic [EW-1:0] model(input logic [3:0] sel, input logic [2:0] off);
      logic [255:0] line;
      logic [31:0]  word;
      logic [1:0]   way;
      bit           found;
      line  = '0;
      way   = '0;
      found = 0;
      for (int w = 0; w < 4; w++) begin
         if (sel[w] && !found) begin
            found = 1;
            line  = data[w];
            way   = 2'(w);
         end
      end
      word = 32'(line >> (int'(off) * 32));
      return {line, word, way, (sel != 4'b0), ($countones(sel) > 1)};
   endfunction

   // driver: called #1 after a rising edge, returns #1 after the accepting edge
   task automatic send(input logic [3:0] sel, input logic [2:0] off, input logic clr);
      bit accepted;
      accepted  = 0;
      i_valid   = 1'b1;
      i_sel     = sel;
      i_offset  = off;
      i_err_clr = clr;
      for (int t = 0; t < 20 && !accepted; t++) begin
         @(negedge clk);
         if (o_ready) begin
            exp_q.push_back(model(sel, off));
            accepted = 1;
         end else begin
            stalls++;
         end
         @(posedge clk);
         #1;
      end
      if (!accepted) check("send_timeout", 320'(0), 320'(1));
      i_valid   = 1'b0;
      i_err_clr = 1'b0;
   endtask

   task automatic idle(input int n);
      i_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n && o_valid && i_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 320'(1), 320'(0));
         end else begin
            check("result", 320'({o_line, o_word, o_way, o_hit, o_multi_hit}), 320'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      i_valid   = 1'b0;
      i_ready   = 1'b0;
      i_sel     = '0;
      i_offset  = '0;
      i_err_clr = 1'b0;
      for (int w = 0; w < 4; w++)
         for (int k = 0; k < 8; k++)
            data[w][k*32 +: 32] = {8'(8'hB0 + w), 8'(k), 16'h1234};
      data[2] = {32{8'hA5}};

      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 320'(o_valid), 320'(0));
      check("rst_ready", 320'(o_ready), 320'(1));
      check("rst_line", 320'(o_line), 320'(0));
      check("rst_word_way_hit", 320'({o_word, o_way, o_hit, o_multi_hit}), 320'(0));
      check("rst_err", 320'(o_err_cnt), 320'(0));
      rst_n   = 1'b1;
      i_ready = 1'b1;
      idle(1);

      // single hit on way 2, word 3
      send(4'b0100, 3'd3, 1'b0);
      check("t1_valid", 320'(o_valid), 320'(1));
      check("t1_way", 320'(o_way), 320'(2));
      check("t1_hit", 320'(o_hit), 320'(1));
      check("t1_word", 320'(o_word), 320'(32'hA5A5A5A5));
      idle(2);

      // miss
      send(4'b0000, 3'd5, 1'b0);
      check("t2_hit", 320'(o_hit), 320'(0));
      check("t2_line", 320'(o_line), 320'(0));
      check("t2_word", 320'(o_word), 320'(0));
      check("t2_err", 320'(o_err_cnt), 320'(0));
      idle(2);

      // multi-hit, saturation, clear priority
      send(4'b1010, 3'd1, 1'b0);
      check("t3_way", 320'(o_way), 320'(1));
      check("t3_multi", 320'(o_multi_hit), 320'(1));
      check("t3_word", 320'(o_word), 320'(32'hB1011234));
      check("t3_err1", 320'(o_err_cnt), 320'(1));
      for (int i = 0; i < 260; i++) send(4'b0011, 3'(i), 1'b0);
      check("t3_err_sat", 320'(o_err_cnt), 320'(255));
      send(4'b1100, 3'd7, 1'b1);
      check("t3_err_clr", 320'(o_err_cnt), 320'(0));
      idle(2);

      // backpressure: fill both entries, then drain
      i_ready = 1'b0;
      send(4'b0001, 3'd0, 1'b0);
      send(4'b1000, 3'd2, 1'b0);
      check("t4_ready_full", 320'(o_ready), 320'(0));
      check("t4_line_a", 320'(o_line), 320'(data[0]));
      idle(3);
      check("t4_line_a_held", 320'(o_line), 320'(data[0]));
      check("t4_valid_held", 320'(o_valid), 320'(1));
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      check("t4_line_b_next", 320'(o_line), 320'(data[3]));
      check("t4_ready_again", 320'(o_ready), 320'(1));
      idle(1);
      check("t4_drained", 320'(o_valid), 320'(0));
      idle(1);

      // streaming, one-hot, no bubbles
      stalls = 0;
      for (int i = 0; i < 16; i++)
         send(4'(1 << $urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'b0);
      check("t5_no_stalls", 320'(stalls), 320'(0));
      check("t5_err", 320'(o_err_cnt), 320'(0));
      idle(3);
      check("t5_drained", 320'(exp_q.size()), 320'(0));

      // async reset while full
      i_ready = 1'b0;
      send(4'b0110, 3'd4, 1'b0);
      send(4'b1100, 3'd6, 1'b0);
      check("t6_err_pre", 320'(o_err_cnt), 320'(2));
      check("t6_full", 320'(o_ready), 320'(0));
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_valid", 320'(o_valid), 320'(0));
      check("t6_ready", 320'(o_ready), 320'(1));
      check("t6_err", 320'(o_err_cnt), 320'(0));
      check("t6_line", 320'(o_line), 320'(0));
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      i_ready = 1'b1;
      idle(1);
      send(4'b0010, 3'd2, 1'b0);
      for (int t = 0; t < 20 && exp_q.size() != 0; t++) idle(1);
      check("final_drained", 320'(exp_q.size()), 320'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
